// File: rtl/aes_key_sched_pkg.sv
// Shared AES constants: FSM encoding, round-constant table and the forward S-box.
package aes_key_sched_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_EMIT} state_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Indexed by round number 1..10; other entries are unused padding.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_key_sched_sbox.sv
// Combinational forward AES S-box lookup for one byte; shared with the SubBytes stage.
module aes_sbox_byte
  import aes_key_sched_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key schedule: loads a cipher key, then hands out round keys 0..10
// over a valid/ready handshake, deriving each next key in a single cycle.
module aes_key_sched
  import aes_key_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d, next_key;
  logic [3:0]   idx_q, idx_d, rcon_idx;
  logic         done_q, done_d;

  logic [31:0] w0, w1, w2, w3, rot_w3, sub_w3, t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3           = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox_byte u_sbox (
      .data_i (rot_w3[8*i +: 8]),
      .data_o (sub_w3[8*i +: 8])
    );
  end

  // The key being produced belongs to round idx_q+1; idx 10 never loads, so padding is harmless.
  assign rcon_idx = idx_q + 4'd1;
  assign t        = sub_w3 ^ {RCON[rcon_idx], 24'h0};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          idx_d   = 4'd0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (idx_q == LAST_ROUND) begin
            // Last key stays visible on round_key after the schedule ends.
            state_d = ST_IDLE;
            idx_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            key_d = next_key;
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= 128'h0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid  = (state_q == ST_EMIT);
  assign busy      = (state_q != ST_IDLE);
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign done      = done_q;

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Iterative AES-128 key schedule that sits directly upstream of the encryption round stage and supplies its 128-bit round-key input. It accepts one cipher key, then emits round keys 0..10 in order, one per accepted handshake, computing each next key in a single cycle from the current one. Backpressure from the round datapath is honoured with a valid/ready handshake.

## Interface
- No parameters. Key size is fixed at 128 bits with 10 rounds.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  load request; sampled only in IDLE
- key_in  in  128  cipher key; key_in[127:120] is byte 0 (FIPS-197 order)
- rk_ready  in  1  consumer accepts round_key this cycle
- rk_valid  out  1  round_key/round_idx are valid
- round_key  out  128  current round key, same byte order as key_in
- round_idx  out  4  index of round_key, 0..10
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse after round 10 is accepted

## Operation
- States are IDLE and EMIT.
- IDLE with start=1: register key_in into the key register, set round_idx=0, and go to EMIT.
- IDLE with start=0: hold all registers.
- EMIT drives rk_valid=1. round_key and round_idx are stable while rk_ready=0.
- EMIT with rk_ready=1 and round_idx<10: the key register loads next_key, and round_idx increments.
- EMIT with rk_ready=1 and round_idx=10: return to IDLE, pulse done, and clear round_idx to 0. round_key holds its last value.
- start is ignored outside IDLE. A new key cannot be loaded mid-schedule.
- next_key is computed from words w0..w3, where w0=key[127:96]:
  - t = SubWord(RotWord(w3)) ^ {rcon[round_idx+1],24'h0}
  - RotWord(w) = {w[23:0],w[31:24]}
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- All arithmetic is bitwise XOR. No carries and no width growth.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE
  - rk_valid=0, busy=0, done=0
  - round_idx=0
  - round_key=128'h0
- Reset asserted mid-schedule aborts immediately. Remaining keys are never emitted and done does not pulse.
- Latency from start (IDLE) to rk_valid=1 with round key 0 is 1 cycle.
- Each handshake produces the next key on the following cycle. With rk_ready held high the block emits 11 keys in 11 consecutive cycles.
- done is asserted the cycle after the round-10 handshake, together with busy=0 and rk_valid=0.
- A start asserted in that same cycle is accepted: round key 0 of the new key is valid on the next cycle.
- rk_valid never deasserts without a handshake, and round_key/round_idx never change while rk_valid=1 and rk_ready=0.
- Outputs are registered. next_key logic is the only combinational path (4 S-box lookups plus an XOR chain) and must close in one clk cycle.

## Structure
- The shared AES package holds:
  - the rcon table as a constant
  - the S-box table
  - the state encoding (ST_IDLE, ST_EMIT)
  - the constant for the last round index, 4'd10
- Sub-module aes_sbox_byte: combinational 8-bit S-box lookup, instantiated 4 times for SubWord. The same module is usable by the subbytes stage.
- Everything else (FSM, key register, round counter, XOR chain) lives in aes_key_sched.

## Test plan
- FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1.
  - idx0 = input key
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done pulses once, the cycle after idx10
- Backpressure: same key, rk_ready toggled randomly.
  - round_key/round_idx are stable while stalled
  - the 11 keys match the full-throughput run exactly
  - no key is skipped or duplicated
- start while busy: assert start with a different key at idx4.
  - ignored; the schedule completes with the original key
- Back-to-back: assert start with key 000102030405060708090a0b0c0d0e0f in the done cycle.
  - new idx0 is valid on the next cycle
  - its idx10 = 13111d7fe3944a17f307a78b4d2b30c5
- Async reset at idx6 while stalled.
  - all outputs are at reset values before the next clk edge
  - no done pulse occurs
  - a subsequent start restarts from idx0
- Idle hold: rk_ready toggling with no start.
  - rk_valid stays 0 and busy stays 0
  - round_key remains 0 after reset
